// File: rtl/sprite_attr_ram.sv
// sprite_attr_ram
// Sprite attribute (OAM) store.
// - The bus side writes BUS_W-bit lanes.
// - A staging register assembles the lanes into a full ENTRY_W entry.
// - The entry is committed to RAM in one write once every lane is present.
// - The sprite evaluator reads whole entries through a registered read port,
//   so rd_data appears one cycle after rd_en.
// - With CLEAR_ON_RESET=1, every entry is zeroed after reset.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   wr_en      : write strobe, one lane per cycle
//   wr_addr    : {entry index, lane}; lane 0 is the most significant lane
//   wr_data    : lane data
//   wr_ready   : writes accepted (not clearing)
//   wr_commit  : one-cycle pulse, a full entry was written to RAM
//   wr_drop    : one-cycle pulse, a partial entry was discarded
//   rd_en      : read request
//   rd_addr    : entry index to read
//   rd_data    : registered entry data, held while rd_en is low
//   rd_valid   : rd_data updated by an accepted read
//   busy       : clear sequence in progress
module sprite_attr_ram #(
    parameter int ENTRY_W        = 32,
    parameter int BUS_W          = 16,
    parameter int DEPTH          = 64,
    parameter int CLEAR_ON_RESET = 1,
    localparam int LANES  = ENTRY_W / BUS_W,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IDX_W+LANE_W-1:0] wr_addr,
    input  logic [BUS_W-1:0]        wr_data,
    output logic                    wr_ready,
    output logic                    wr_commit,
    output logic                    wr_drop,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        rd_addr,
    output logic [ENTRY_W-1:0]      rd_data,
    output logic                    rd_valid,
    output logic                    busy
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     clr_cnt;

    logic [ENTRY_W-1:0]   stage_data;
    logic [IDX_W-1:0]     stage_tag;
    logic [LANES-1:0]     stage_mask;

    logic [IDX_W-1:0]     wr_idx;
    logic [LANE_W-1:0]    wr_lane;
    logic [31:0]          lane_ext;
    logic                 lane_ok;
    logic                 wr_take;
    logic [LANES-1:0]     lane_sel;
    logic                 mismatch;
    logic [LANES-1:0]     mask_next;
    logic [ENTRY_W-1:0]   merged;
    logic                 do_commit;
    logic                 do_drop;

    logic                 ram_we;
    logic [IDX_W-1:0]     ram_waddr;
    logic [ENTRY_W-1:0]   ram_wdata;
    logic                 rd_fire;

    logic [ENTRY_W-1:0]   ram [DEPTH];

    assign wr_idx   = wr_addr[IDX_W+LANE_W-1:LANE_W];
    assign wr_lane  = wr_addr[LANE_W-1:0];
    assign lane_ext = 32'(wr_lane);
    // A lane code beyond LANES-1 (only possible when LANES is not a power of two) is ignored.
    assign lane_ok  = (lane_ext < 32'(LANES));

    // ---- control FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // ---- control FSM: next state ----
    always_comb begin
        state_next = state;
        if (state == S_CLEAR && clr_cnt == IDX_W'(DEPTH - 1)) begin
            state_next = S_RUN;
        end
    end

    // ---- control FSM: outputs ----
    always_comb begin
        busy     = (state == S_CLEAR);
        wr_ready = (state == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // ---- write assembly: merge incoming lane with staging ----
    always_comb begin
        wr_take  = (state == S_RUN) && wr_en && lane_ok;
        lane_sel = '0;
        merged   = stage_data;
        for (int k = 0; k < LANES; k++) begin
            lane_sel[k] = (lane_ext == 32'(k));
            if (lane_sel[k]) begin
                merged[ENTRY_W-1-k*BUS_W -: BUS_W] = wr_data;
            end
        end
        // A write to a different entry abandons the partial one and restarts from this lane.
        mismatch  = (stage_mask != '0) && (wr_idx != stage_tag);
        mask_next = mismatch ? lane_sel : (stage_mask | lane_sel);
        do_commit = wr_take && (mask_next == '1);
        do_drop   = wr_take && mismatch;
    end

    // The RAM has one write port, shared by the clear sequence and entry commits.
    // Every commit targets the incoming index, so wr_idx is also the write address.
    always_comb begin
        if (state == S_CLEAR) begin
            ram_we    = !reset;
            ram_waddr = clr_cnt;
            ram_wdata = '0;
        end else begin
            ram_we    = do_commit && !reset;
            ram_waddr = wr_idx;
            ram_wdata = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_mask <= '0;
        end else if (wr_take) begin
            stage_mask <= do_commit ? '0 : mask_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_take) begin
            stage_data <= merged;
            stage_tag  <= wr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_commit <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            wr_commit <= do_commit;
            wr_drop   <= do_drop;
        end
    end

    // ---- RAM write / registered read (read-first on address collision) ----
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    assign rd_fire = rd_en && (state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= ram[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_sprite_attr_ram.sv
module tb_sprite_attr_ram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default 32-bit entries, 64 deep, clear on reset
    logic        rst = 1'b1, we = 1'b0, re = 1'b0;
    logic [6:0]  wa = '0;
    logic [15:0] wd = '0;
    logic [5:0]  ra = '0;
    logic        ready, commit, drop, rv, busy;
    logic [31:0] rdata;

    sprite_attr_ram dut_a (
        .clk(clk), .reset(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .wr_ready(ready), .wr_commit(commit), .wr_drop(drop),
        .rd_en(re), .rd_addr(ra), .rd_data(rdata), .rd_valid(rv), .busy(busy)
    );

    // DUT B: 64-bit entries of four lanes, 16 deep, no clear
    logic        b_rst = 1'b1, b_we = 1'b0, b_re = 1'b0;
    logic [5:0]  b_wa = '0;
    logic [15:0] b_wd = '0;
    logic [3:0]  b_ra = '0;
    logic        b_ready, b_commit, b_drop, b_rv, b_busy;
    logic [63:0] b_rdata;

    sprite_attr_ram #(.ENTRY_W(64), .BUS_W(16), .DEPTH(16), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .reset(b_rst), .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd),
        .wr_ready(b_ready), .wr_commit(b_commit), .wr_drop(b_drop),
        .rd_en(b_re), .rd_addr(b_ra), .rd_data(b_rdata), .rd_valid(b_rv), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model of DUT A: memory image, clear countdown, staged lanes
    bit [31:0] mem [64];
    int        clear_left = 64;
    bit [5:0]  tag;
    bit [15:0] lanes [2];
    bit [1:0]  vmask;
    bit        m_commit, m_drop, m_rv;
    bit [31:0] m_rd;

    task automatic cyc(input bit r, input bit w, input logic [6:0] a, input logic [15:0] d,
                       input bit e, input logic [5:0] rai);
        bit [5:0] idx;
        bit       ln;
        rst = r; we = w; wa = a; wd = d; re = e; ra = rai;
        m_commit = 0; m_drop = 0;
        if (r) begin
            clear_left = 64; vmask = '0; m_rv = 0; m_rd = '0;
            for (int i = 0; i < 64; i++) mem[i] = '0;
        end else if (clear_left > 0) begin
            clear_left--; m_rv = 0;
        end else begin
            m_rv = e;
            if (e) m_rd = mem[rai];
            if (w) begin
                idx = a[6:1]; ln = a[0];
                if (vmask != 0 && idx != tag) begin
                    m_drop = 1; vmask = '0;
                end
                tag = idx;
                lanes[ln] = d;
                vmask[ln] = 1'b1;
                if (vmask == 2'b11) begin
                    mem[tag] = {lanes[0], lanes[1]};
                    m_commit = 1; vmask = '0;
                end
            end
        end
        @(posedge clk); #1;
        chk("busy", busy, (clear_left > 0));
        chk("wr_ready", ready, (clear_left == 0));
        chk("wr_commit", commit, m_commit);
        chk("wr_drop", drop, m_drop);
        chk("rd_valid", rv, m_rv);
        chk("rd_data", rdata, m_rd);
    endtask

    task automatic bcyc(input bit r, input bit w, input logic [5:0] a, input logic [15:0] d,
                        input bit e, input logic [3:0] rai,
                        input bit xc, input bit xd, input bit xv, input logic [63:0] xr);
        b_rst = r; b_we = w; b_wa = a; b_wd = d; b_re = e; b_ra = rai;
        @(posedge clk); #1;
        chk("b_busy", b_busy, 1'b0);
        chk("b_wr_ready", b_ready, 1'b1);
        chk("b_wr_commit", b_commit, xc);
        chk("b_wr_drop", b_drop, xd);
        chk("b_rd_valid", b_rv, xv);
        chk("b_rd_data", b_rdata, xr);
    endtask

    typedef struct {
        bit          w;
        logic [6:0]  a;
        logic [15:0] d;
        bit          e;
        logic [5:0]  ra;
        bit          xc;
        bit          xd;
        bit          xv;
        logic [31:0] xr;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(bit w, logic [6:0] a, logic [15:0] d, bit e, logic [5:0] r,
                                bit xc, bit xd, bit xv, logic [31:0] xr);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.e = e; v.ra = r;
        v.xc = xc; v.xd = xd; v.xv = xv; v.xr = xr;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        //                 w   addr    data      re  ra      cm  dr  rv  rd
        tbl[0]  = mk(1, 7'h0A, 16'hBEEF, 0, 6'd0, 0, 0, 0, 32'h0000_0000);
        tbl[1]  = mk(1, 7'h0B, 16'hCAFE, 0, 6'd0, 1, 0, 0, 32'h0000_0000);
        tbl[2]  = mk(0, 7'h00, 16'h0000, 1, 6'd5, 0, 0, 1, 32'hBEEF_CAFE);
        tbl[3]  = mk(1, 7'h0B, 16'h1234, 0, 6'd0, 0, 0, 0, 32'hBEEF_CAFE);
        tbl[4]  = mk(1, 7'h0A, 16'h5678, 0, 6'd0, 1, 0, 0, 32'hBEEF_CAFE);
        tbl[5]  = mk(0, 7'h00, 16'h0000, 1, 6'd5, 0, 0, 1, 32'h5678_1234);
        tbl[6]  = mk(1, 7'h0A, 16'hAAAA, 0, 6'd0, 0, 0, 0, 32'h5678_1234);
        tbl[7]  = mk(1, 7'h0C, 16'h1111, 0, 6'd0, 0, 1, 0, 32'h5678_1234);
        tbl[8]  = mk(1, 7'h0D, 16'h2222, 0, 6'd0, 1, 0, 0, 32'h5678_1234);
        tbl[9]  = mk(0, 7'h00, 16'h0000, 1, 6'd5, 0, 0, 1, 32'h5678_1234);
        tbl[10] = mk(0, 7'h00, 16'h0000, 1, 6'd6, 0, 0, 1, 32'h1111_2222);
        tbl[11] = mk(1, 7'h06, 16'hDEAD, 1, 6'd3, 0, 0, 1, 32'h0000_0000);
        tbl[12] = mk(1, 7'h07, 16'hBEEF, 1, 6'd3, 1, 0, 1, 32'h0000_0000);
        tbl[13] = mk(0, 7'h00, 16'h0000, 1, 6'd3, 0, 0, 1, 32'hDEAD_BEEF);
        tbl[14] = mk(1, 7'h10, 16'h1111, 0, 6'd0, 0, 0, 0, 32'hDEAD_BEEF);
        tbl[15] = mk(1, 7'h10, 16'h2222, 0, 6'd0, 0, 0, 0, 32'hDEAD_BEEF);
        tbl[16] = mk(1, 7'h11, 16'h3333, 0, 6'd0, 1, 0, 0, 32'hDEAD_BEEF);
        tbl[17] = mk(0, 7'h00, 16'h0000, 1, 6'd8, 0, 0, 1, 32'h2222_3333);

        // Reset, then clear length with bus traffic that must be ignored
        cyc(1, 0, 7'h0, 16'h0, 0, 6'h0);
        cyc(1, 1, 7'h0A, 16'h5555, 1, 6'h5);
        n = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 6'($urandom));
            n++;
        end
        chk("clear_len", 64'(n), 64'd64);
        for (int i = 0; i < 64; i++) cyc(0, 0, 7'h0, 16'h0, 1, 6'(i));
        cyc(0, 0, 7'h0, 16'h0, 0, 6'h0);

        // Directed vectors
        for (int i = 0; i < 18; i++) begin
            cyc(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].ra);
            chk($sformatf("vec%0d_commit", i), commit, tbl[i].xc);
            chk($sformatf("vec%0d_drop", i), drop, tbl[i].xd);
            chk($sformatf("vec%0d_rv", i), rv, tbl[i].xv);
            chk($sformatf("vec%0d_rd", i), rdata, tbl[i].xr);
        end

        // Random traffic over a few entries so tags collide often
        for (int i = 0; i < 400; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 16'($urandom),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)));
        end

        // Partial entry, reset, reset again mid-clear at counter 20
        cyc(0, 1, 7'h12, 16'h7777, 0, 6'h0);
        cyc(1, 0, 7'h0, 16'h0, 0, 6'h0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 7'h0, 16'h0, 0, 6'h0);
        cyc(1, 0, 7'h0, 16'h0, 0, 6'h0);
        n = 1;
        for (int i = 0; i < 200 && busy; i++) begin
            cyc(0, 0, 7'h0, 16'h0, 0, 6'h0);
            if (busy) n++;
        end
        chk("reclear_len", 64'(n), 64'd64);
        cyc(0, 1, 7'h13, 16'h8888, 0, 6'h0);
        chk("lost_partial_no_commit", commit, 1'b0);
        cyc(0, 1, 7'h12, 16'h9999, 0, 6'h0);
        chk("refill_commit", commit, 1'b1);
        cyc(0, 0, 7'h0, 16'h0, 1, 6'd9);
        chk("refill_rd", rdata, 32'h9999_8888);

        // Four-lane variant, no clear
        rst = 0; we = 0; re = 0;
        bcyc(1, 0, 6'h00, 16'h0000, 0, 4'd0, 0, 0, 0, 64'h0);
        bcyc(0, 1, 6'h0B, 16'h4444, 0, 4'd0, 0, 0, 0, 64'h0);
        bcyc(0, 1, 6'h09, 16'h2222, 0, 4'd0, 0, 0, 0, 64'h0);
        bcyc(0, 1, 6'h08, 16'h1111, 0, 4'd0, 0, 0, 0, 64'h0);
        bcyc(0, 1, 6'h0A, 16'h3333, 0, 4'd0, 1, 0, 0, 64'h0);
        bcyc(0, 0, 6'h00, 16'h0000, 1, 4'd2, 0, 0, 1, 64'h1111_2222_3333_4444);
        bcyc(0, 1, 6'h0C, 16'hAAAA, 0, 4'd0, 0, 0, 0, 64'h1111_2222_3333_4444);
        bcyc(0, 1, 6'h10, 16'hBBBB, 0, 4'd0, 0, 1, 0, 64'h1111_2222_3333_4444);
        bcyc(1, 0, 6'h00, 16'h0000, 0, 4'd0, 0, 0, 0, 64'h0);
        bcyc(0, 1, 6'h15, 16'hCCCC, 0, 4'd0, 0, 0, 0, 64'h0);
        bcyc(0, 0, 6'h00, 16'h0000, 0, 4'd0, 0, 0, 0, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
